// File: rtl/register_bank.sv
// DEPTH x WIDTH history store with enable-gated load/shift/rotate/clear and per-entry valid flags.
// Contents and status update together on the clock edge; reads are combinational from current state.
module register_bank #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] Data,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_tail,
   output logic [AW:0]      occupancy,
   output logic             full,
   output logic             empty
);

   typedef enum logic [1:0] {
      MODE_LOAD   = 2'b00,
      MODE_SHIFT  = 2'b01,
      MODE_ROTATE = 2'b10,
      MODE_CLEAR  = 2'b11
   } mode_e;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [WIDTH-1:0] entry_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [AW:0]      occ_q, occ_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             addr_ok;

   // Addresses beyond DEPTH drop writes and read as zero.
   assign addr_ok = ({1'b0, addr} < DEPTH_W);

   always_comb begin
      entry_d = entry_q;
      valid_d = valid_q;
      if (enable) begin
         case (mode_e'(mode))
            MODE_LOAD: begin
               if (addr_ok) begin
                  entry_d[addr] = Data;
                  valid_d[addr] = 1'b1;
               end
            end
            MODE_SHIFT: begin
               entry_d[0] = Data;
               for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
               valid_d = {valid_q[DEPTH-2:0], 1'b1};
            end
            MODE_ROTATE: begin
               entry_d[0] = entry_q[DEPTH-1];
               for (int i = 1; i < DEPTH; i++) entry_d[i] = entry_q[i-1];
               valid_d = {valid_q[DEPTH-2:0], valid_q[DEPTH-1]};
            end
            MODE_CLEAR: begin
               for (int i = 0; i < DEPTH; i++) entry_d[i] = '0;
               valid_d = '0;
            end
            default: ;
         endcase
      end
   end

   // Status is computed from the next valid vector so it never lags the data.
   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) occ_d = occ_d + {{AW{1'b0}}, valid_d[i]};
      full_d  = (occ_d == DEPTH_W);
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         valid_q <= '0;
         occ_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
         valid_q <= valid_d;
         occ_q   <= occ_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign Q         = addr_ok ? entry_q[addr] : '0;
   assign Q_tail    = entry_q[DEPTH-1];
   assign occupancy = occ_q;
   assign full      = full_q;
   assign empty     = empty_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank at WIDTH=5, DEPTH=4, AW=2.
module tb_register_bank;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [1:0] mode;
   logic [1:0] addr;
   logic [4:0] Data;
   logic [4:0] Q;
   logic [4:0] Q_tail;
   logic [2:0] occupancy;
   logic       full;
   logic       empty;

   int checks;
   int failures;

   register_bank #(.WIDTH(5), .DEPTH(4), .AW(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .mode      (mode),
      .addr      (addr),
      .Data      (Data),
      .Q         (Q),
      .Q_tail    (Q_tail),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      enable = 1'b1; mode = 2'b11;
      step();
      enable = 1'b0;
   endtask

   task automatic shift_in(input logic [4:0] d);
      enable = 1'b1; mode = 2'b01; Data = d;
      step();
      enable = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; mode = 2'b00; addr = 2'd0; Data = 5'h00;
      #22;
      checks++; if (Q !== 5'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", Q); end
      checks++; if (Q_tail !== 5'h00) begin failures++; $display("FAIL reset_qtail got=%h exp=00", Q_tail); end
      checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_hold();
      enable = 1'b0; mode = 2'b01; Data = 5'h1F; addr = 2'd0;
      repeat (3) step();
      checks++; if (Q !== 5'h00) begin failures++; $display("FAIL hold_q got=%h exp=00", Q); end
      checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL hold_occ got=%0d exp=0", occupancy); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL hold_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
   endtask

   task automatic test_load();
      enable = 1'b1; mode = 2'b00; addr = 2'd2; Data = 5'h0A;
      step();
      enable = 1'b0;
      checks++; if (Q !== 5'h0A) begin failures++; $display("FAIL load_q2 got=%h exp=0a", Q); end
      checks++; if (occupancy !== 3'd1 || empty !== 1'b0) begin failures++; $display("FAIL load_occ1 got occ=%0d empty=%b exp occ=1 empty=0", occupancy, empty); end
      enable = 1'b1; addr = 2'd3; Data = 5'h05;
      step();
      enable = 1'b0;
      checks++; if (Q_tail !== 5'h05) begin failures++; $display("FAIL load_tail got=%h exp=05", Q_tail); end
      checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL load_occ2 got=%0d exp=2", occupancy); end
   endtask

   task automatic test_shift();
      do_clear();
      for (int i = 1; i <= 4; i++) shift_in(5'(i));
      checks++; if (full !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL shift_full got full=%b empty=%b exp full=1 empty=0", full, empty); end
      checks++; if (Q_tail !== 5'h01) begin failures++; $display("FAIL shift_tail4 got=%h exp=01", Q_tail); end
      shift_in(5'h05);
      addr = 2'd0; #1;
      checks++; if (Q_tail !== 5'h02) begin failures++; $display("FAIL shift_tail5 got=%h exp=02", Q_tail); end
      checks++; if (Q !== 5'h05) begin failures++; $display("FAIL shift_head got=%h exp=05", Q); end
      checks++; if (occupancy !== 3'd4 || full !== 1'b1) begin failures++; $display("FAIL shift_occ got occ=%0d full=%b exp occ=4 full=1", occupancy, full); end
   endtask

   task automatic test_rotate();
      logic [4:0] exp_r [4];
      exp_r[0] = 5'h01; exp_r[1] = 5'h04; exp_r[2] = 5'h03; exp_r[3] = 5'h02;
      do_clear();
      for (int i = 1; i <= 4; i++) shift_in(5'(i));
      enable = 1'b1; mode = 2'b10;
      step();
      enable = 1'b0;
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a); #1;
         checks++; if (Q !== exp_r[a]) begin failures++; $display("FAIL rotate_entry%0d got=%h exp=%h", a, Q, exp_r[a]); end
      end
      checks++; if (occupancy !== 3'd4 || full !== 1'b1) begin failures++; $display("FAIL rotate_occ got occ=%0d full=%b exp occ=4 full=1", occupancy, full); end
   endtask

   task automatic test_clear();
      do_clear();
      checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL clear_occ got=%0d exp=0", occupancy); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL clear_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a); #1;
         checks++; if (Q !== 5'h00) begin failures++; $display("FAIL clear_entry%0d got=%h exp=00", a, Q); end
      end
      checks++; if (Q_tail !== 5'h00) begin failures++; $display("FAIL clear_tail got=%h exp=00", Q_tail); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) shift_in(5'h0C);
      checks++; if (Q_tail !== 5'h0C) begin failures++; $display("FAIL areset_pre got=%h exp=0c", Q_tail); end
      addr = 2'd0; enable = 1'b1; mode = 2'b01; Data = 5'h1F;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (Q_tail !== 5'h00 || Q !== 5'h00) begin failures++; $display("FAIL areset_data got q=%h tail=%h exp 00 00", Q, Q_tail); end
      checks++; if (occupancy !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL areset_status got occ=%0d empty=%b full=%b exp 0 1 0", occupancy, empty, full); end
      enable = 1'b0;
      #3 rst_n = 1'b1;
      step();
      checks++; if (occupancy !== 3'd0 || Q_tail !== 5'h00) begin failures++; $display("FAIL areset_after got occ=%0d tail=%h exp 0 00", occupancy, Q_tail); end
   endtask

   task automatic test_read_during_write();
      enable = 1'b1; mode = 2'b00; addr = 2'd1; Data = 5'h07;
      step();
      Data = 5'h11;
      #1;
      checks++; if (Q !== 5'h07) begin failures++; $display("FAIL rdw_before got=%h exp=07", Q); end
      step();
      enable = 1'b0;
      checks++; if (Q !== 5'h11) begin failures++; $display("FAIL rdw_after got=%h exp=11", Q); end
      checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL rdw_occ got=%0d exp=1", occupancy); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_hold();
      test_load();
      test_shift();
      test_rotate();
      test_clear();
      test_async_reset();
      test_read_during_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
